dma_fifo_writer: RTL and testbench



---
 rtl/dma_fifo_writer.sv | 103 ++++++++++
 tb/tb_dma_fifo_writer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_fifo_writer.sv
// DMA FIFO drain stage: pops words from the FIFO and writes them to memory as
// single-word req/gnt transfers at consecutive byte addresses.
module dma_fifo_writer #(
    parameter int unsigned C_WIDTH      = 64,
    parameter int unsigned C_ADDR_WIDTH = 32,
    parameter int unsigned C_LEN_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    start_i,
    input  logic [C_ADDR_WIDTH-1:0] base_addr_i,
    input  logic [C_LEN_WIDTH-1:0]  len_i,
    output logic                    busy_o,
    output logic                    done_o,
    input  logic [C_WIDTH-1:0]      fifo_data_i,
    input  logic                    fifo_empty_i,
    output logic                    fifo_pop_o,
    output logic                    mem_req_o,
    output logic [C_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [C_WIDTH-1:0]      mem_wdata_o,
    input  logic                    mem_gnt_i
);

    localparam int unsigned C_BYTES = C_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_REQ,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic [C_ADDR_WIDTH-1:0] r_addr;
    logic [C_LEN_WIDTH-1:0]  r_remaining;
    logic [C_WIDTH-1:0]      r_wdata;

    logic w_grant;
    logic w_last;

    assign w_grant = (r_state == S_REQ) && mem_gnt_i;
    assign w_last  = (r_remaining == C_LEN_WIDTH'(1));

    // Pop on a FETCH hit, or prefetch the next word on a non-final grant.
    assign fifo_pop_o = !fifo_empty_i &&
                        ((r_state == S_FETCH) || (w_grant && !w_last));

    assign busy_o      = (r_state == S_FETCH) || (r_state == S_REQ);
    assign mem_req_o   = (r_state == S_REQ);
    assign done_o      = (r_state == S_DONE);
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_wdata     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        if (len_i != '0) begin
                            r_addr      <= base_addr_i;
                            r_remaining <= len_i;
                            r_state     <= S_FETCH;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_FETCH: begin
                    if (!fifo_empty_i) begin
                        r_wdata <= fifo_data_i;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_gnt_i) begin
                        // Address wraps modulo 2^C_ADDR_WIDTH by truncation.
                        r_addr      <= r_addr + C_ADDR_WIDTH'(C_BYTES);
                        r_remaining <= r_remaining - C_LEN_WIDTH'(1);
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else if (!fifo_empty_i) begin
                            r_wdata <= fifo_data_i;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_fifo_writer.sv
// Testbench for dma_fifo_writer: FIFO model, grant generator, write monitor and
// a scoreboard of expected memory writes, one task per scenario.
module tb_dma_fifo_writer;

    localparam int unsigned W  = 64;
    localparam int unsigned AW = 32;
    localparam int unsigned LW = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rstn_i = 1'b0;
    logic          start_i = 1'b0;
    logic [AW-1:0] base_addr_i = '0;
    logic [LW-1:0] len_i = '0;
    logic          busy_o;
    logic          done_o;
    logic [W-1:0]  fifo_data_i;
    logic          fifo_empty_i;
    logic          fifo_pop_o;
    logic          mem_req_o;
    logic [AW-1:0] mem_addr_o;
    logic [W-1:0]  mem_wdata_o;
    logic          mem_gnt_i = 1'b0;

    int nvec = 0;
    int nfail = 0;

    dma_fifo_writer #(.C_WIDTH(W), .C_ADDR_WIDTH(AW), .C_LEN_WIDTH(LW)) dut (
        .clk_i(clk), .rstn_i(rstn_i), .start_i(start_i),
        .base_addr_i(base_addr_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o),
        .fifo_data_i(fifo_data_i), .fifo_empty_i(fifo_empty_i), .fifo_pop_o(fifo_pop_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i)
    );

    always #5 clk = ~clk;

    // FIFO model: pushed by the tasks, popped on the DUT strobe.
    logic [W-1:0] fmem [0:63];
    int unsigned  wr_ptr = 0;
    int unsigned  rd_ptr = 0;
    int           pop_cnt = 0;
    int           pop_empty_cnt = 0;
    assign fifo_empty_i = (wr_ptr == rd_ptr);
    assign fifo_data_i  = fmem[rd_ptr[5:0]];

    always @(posedge clk) begin
        if (fifo_pop_o && !fifo_empty_i) begin
            rd_ptr  <= rd_ptr + 1;
            pop_cnt <= pop_cnt + 1;
        end
        if (fifo_pop_o && fifo_empty_i) pop_empty_cnt <= pop_empty_cnt + 1;
    end

    // Grant generator: gnt_delay=0 ties grant high, else holds it low that many cycles per request.
    int gnt_delay = 0;
    int wait_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (gnt_delay == 0) begin
            mem_gnt_i = 1'b1;
        end else if (mem_req_o && wait_cnt < gnt_delay) begin
            mem_gnt_i = 1'b0;
            wait_cnt  = wait_cnt + 1;
        end else if (mem_req_o) begin
            mem_gnt_i = 1'b1;
            wait_cnt  = 0;
        end else begin
            mem_gnt_i = 1'b0;
        end
    end

    // Write monitor: records completed transfers and request stability violations.
    wr_t  exp_q[$];
    wr_t  obs_q[$];
    int   gcyc_q[$];
    int   cyc = 0;
    int   grant_cnt = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   stab_err = 0;
    logic prev_wait = 1'b0;
    wr_t  prev_wr = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rstn_i && mem_req_o && mem_gnt_i) begin
            obs_q.push_back(wr_t'({mem_addr_o, mem_wdata_o}));
            gcyc_q.push_back(cyc);
            grant_cnt <= grant_cnt + 1;
        end
        if (rstn_i && done_o) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (rstn_i && prev_wait && mem_req_o && (prev_wr != wr_t'({mem_addr_o, mem_wdata_o})))
            stab_err <= stab_err + 1;
        prev_wait <= rstn_i && mem_req_o && !mem_gnt_i;
        prev_wr   <= wr_t'({mem_addr_o, mem_wdata_o});
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic push_word(input logic [W-1:0] d);
        fmem[wr_ptr[5:0]] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic start_xfer(input logic [AW-1:0] base, input logic [LW-1:0] len);
        start_i     = 1'b1;
        base_addr_i = base;
        len_i       = len;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen, output logic busy_at_done);
        seen = 1'b0;
        busy_at_done = 1'bx;
        for (int i = 0; i < budget; i++) begin
            if (done_o) begin
                seen = 1'b1;
                busy_at_done = busy_o;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        tick();
        tick();
        nvec++; if (busy_o !== 1'b0) begin nfail++; $display("FAIL reset_busy got %b want 0", busy_o); end
        nvec++; if (done_o !== 1'b0) begin nfail++; $display("FAIL reset_done got %b want 0", done_o); end
        nvec++; if (fifo_pop_o !== 1'b0) begin nfail++; $display("FAIL reset_pop got %b want 0", fifo_pop_o); end
        nvec++; if (mem_req_o !== 1'b0) begin nfail++; $display("FAIL reset_req got %b want 0", mem_req_o); end
        nvec++; if (mem_addr_o !== '0) begin nfail++; $display("FAIL reset_addr got %h want 0", mem_addr_o); end
        nvec++; if (mem_wdata_o !== '0) begin nfail++; $display("FAIL reset_wdata got %h want 0", mem_wdata_o); end
        rstn_i = 1'b1;
        tick();
    endtask

    task automatic test_basic_burst();
        bit seen; logic b; int p0; wr_t e, o;
        gnt_delay = 0; exp_q.delete(); obs_q.delete(); gcyc_q.delete();
        p0 = pop_cnt;
        for (int i = 0; i < 4; i++) begin
            push_word(W'(64'hA0 + i));
            exp_q.push_back(wr_t'{addr: AW'(32'h1000 + 8 * i), data: W'(64'hA0 + i)});
        end
        tick();
        start_xfer(32'h1000, 16'd4);
        nvec++; if (busy_o !== 1'b1) begin nfail++; $display("FAIL basic_fetch_busy got %b want 1", busy_o); end
        nvec++; if (fifo_pop_o !== 1'b1) begin nfail++; $display("FAIL basic_fetch_pop got %b want 1", fifo_pop_o); end
        nvec++; if (mem_req_o !== 1'b0) begin nfail++; $display("FAIL basic_fetch_req got %b want 0", mem_req_o); end
        tick();
        nvec++; if (mem_req_o !== 1'b1) begin nfail++; $display("FAIL basic_first_req got %b want 1", mem_req_o); end
        nvec++; if (mem_addr_o !== 32'h1000) begin nfail++; $display("FAIL basic_first_addr got %h want 1000", mem_addr_o); end
        wait_done(20, seen, b);
        nvec++; if (!seen) begin nfail++; $display("FAIL basic_done_timeout got none want pulse"); end
        nvec++; if (b !== 1'b0) begin nfail++; $display("FAIL basic_busy_at_done got %b want 0", b); end
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); nvec++;
            if (obs_q.size() == 0) begin nfail++; $display("FAIL basic_write got none want %h/%h", e.addr, e.data); end
            else begin o = obs_q.pop_front();
                if (o !== e) begin nfail++; $display("FAIL basic_write got %h/%h want %h/%h", o.addr, o.data, e.addr, e.data); end end
        end
        nvec++; if (obs_q.size() != 0) begin nfail++; $display("FAIL basic_extra_writes got %0d want 0", obs_q.size()); end
        nvec++; if (gcyc_q.size() != 4 || gcyc_q[3] - gcyc_q[0] != 3) begin nfail++; $display("FAIL basic_consecutive got %0d grants want 4 in 4 cycles", gcyc_q.size()); end
        nvec++; if (gcyc_q.size() == 4 && done_cyc != gcyc_q[3] + 1) begin nfail++; $display("FAIL basic_done_cycle got %0d want %0d", done_cyc, gcyc_q[3] + 1); end
        nvec++; if (pop_cnt - p0 != 4) begin nfail++; $display("FAIL basic_pops got %0d want 4", pop_cnt - p0); end
    endtask

    task automatic test_backpressure();
        bit seen; logic b; int p0, s0, g0; wr_t e, o;
        gnt_delay = 3; exp_q.delete(); obs_q.delete();
        p0 = pop_cnt; s0 = stab_err; g0 = grant_cnt;
        for (int i = 0; i < 3; i++) begin
            push_word(W'(64'hB0 + i));
            exp_q.push_back(wr_t'{addr: AW'(32'h2000 + 8 * i), data: W'(64'hB0 + i)});
        end
        start_xfer(32'h2000, 16'd3);
        wait_done(60, seen, b);
        nvec++; if (!seen) begin nfail++; $display("FAIL bp_done_timeout got none want pulse"); end
        tick();
        nvec++; if (stab_err != s0) begin nfail++; $display("FAIL bp_stable got %0d changes want 0", stab_err - s0); end
        nvec++; if (pop_cnt - p0 != 3) begin nfail++; $display("FAIL bp_pops got %0d want 3", pop_cnt - p0); end
        nvec++; if (grant_cnt - g0 != 3) begin nfail++; $display("FAIL bp_grants got %0d want 3", grant_cnt - g0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); nvec++;
            if (obs_q.size() == 0) begin nfail++; $display("FAIL bp_write got none want %h/%h", e.addr, e.data); end
            else begin o = obs_q.pop_front();
                if (o !== e) begin nfail++; $display("FAIL bp_write got %h/%h want %h/%h", o.addr, o.data, e.addr, e.data); end end
        end
        gnt_delay = 0;
    endtask

    task automatic test_starvation();
        bit seen; logic b; int p0, pe0; wr_t e, o;
        gnt_delay = 0; exp_q.delete(); obs_q.delete();
        p0 = pop_cnt; pe0 = pop_empty_cnt;
        start_xfer(32'h5000, 16'd3);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 5; i++) begin
                nvec++; if (busy_o !== 1'b1) begin nfail++; $display("FAIL starve_busy got %b want 1", busy_o); end
                if (i >= 2) begin
                    nvec++; if (mem_req_o !== 1'b0) begin nfail++; $display("FAIL starve_req_empty got %b want 0", mem_req_o); end
                end
                tick();
            end
            push_word(W'(64'hC0 + k));
            exp_q.push_back(wr_t'{addr: AW'(32'h5000 + 8 * k), data: W'(64'hC0 + k)});
        end
        wait_done(20, seen, b);
        nvec++; if (!seen) begin nfail++; $display("FAIL starve_done_timeout got none want pulse"); end
        tick();
        nvec++; if (pop_empty_cnt != pe0) begin nfail++; $display("FAIL starve_pop_empty got %0d want 0", pop_empty_cnt - pe0); end
        nvec++; if (pop_cnt - p0 != 3) begin nfail++; $display("FAIL starve_pops got %0d want 3", pop_cnt - p0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); nvec++;
            if (obs_q.size() == 0) begin nfail++; $display("FAIL starve_write got none want %h/%h", e.addr, e.data); end
            else begin o = obs_q.pop_front();
                if (o !== e) begin nfail++; $display("FAIL starve_write got %h/%h want %h/%h", o.addr, o.data, e.addr, e.data); end end
        end
    endtask

    task automatic test_len_zero();
        int p0, g0;
        p0 = pop_cnt; g0 = grant_cnt;
        push_word(W'(64'hDEAD));
        start_xfer(32'h6000, 16'd0);
        nvec++; if (done_o !== 1'b1) begin nfail++; $display("FAIL len0_done got %b want 1", done_o); end
        nvec++; if (busy_o !== 1'b0) begin nfail++; $display("FAIL len0_busy got %b want 0", busy_o); end
        nvec++; if (mem_req_o !== 1'b0) begin nfail++; $display("FAIL len0_req got %b want 0", mem_req_o); end
        tick();
        nvec++; if (done_o !== 1'b0) begin nfail++; $display("FAIL len0_done_width got %b want 0", done_o); end
        tick();
        nvec++; if (pop_cnt != p0 || grant_cnt != g0) begin nfail++; $display("FAIL len0_activity got %0d pops %0d grants want 0 0", pop_cnt - p0, grant_cnt - g0); end
        rd_ptr = wr_ptr;
    endtask

    task automatic test_start_while_busy();
        bit seen; logic b; int g0; wr_t e, o;
        gnt_delay = 3; exp_q.delete(); obs_q.delete(); g0 = grant_cnt;
        for (int i = 0; i < 3; i++) begin
            push_word(W'(64'hD0 + i));
            exp_q.push_back(wr_t'{addr: AW'(32'h7000 + 8 * i), data: W'(64'hD0 + i)});
        end
        start_xfer(32'h7000, 16'd3);
        tick(); tick();
        start_i = 1'b1; base_addr_i = 32'h9000; len_i = 16'd5;
        tick();
        start_i = 1'b0;
        wait_done(60, seen, b);
        nvec++; if (!seen) begin nfail++; $display("FAIL swb_done_timeout got none want pulse"); end
        for (int i = 0; i < 5; i++) begin
            tick();
            nvec++; if (busy_o !== 1'b0 || mem_req_o !== 1'b0) begin nfail++; $display("FAIL swb_idle got busy %b req %b want 0 0", busy_o, mem_req_o); end
        end
        nvec++; if (grant_cnt - g0 != 3) begin nfail++; $display("FAIL swb_grants got %0d want 3", grant_cnt - g0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); nvec++;
            if (obs_q.size() == 0) begin nfail++; $display("FAIL swb_write got none want %h/%h", e.addr, e.data); end
            else begin o = obs_q.pop_front();
                if (o !== e) begin nfail++; $display("FAIL swb_write got %h/%h want %h/%h", o.addr, o.data, e.addr, e.data); end end
        end
        gnt_delay = 0;
    endtask

    task automatic test_addr_wrap();
        bit seen; logic b; wr_t e, o;
        gnt_delay = 0; exp_q.delete(); obs_q.delete();
        push_word(W'(64'hE0)); push_word(W'(64'hE1));
        exp_q.push_back(wr_t'{addr: 32'hFFFF_FFF8, data: W'(64'hE0)});
        exp_q.push_back(wr_t'{addr: 32'h0000_0000, data: W'(64'hE1)});
        start_xfer(32'hFFFF_FFF8, 16'd2);
        wait_done(20, seen, b);
        nvec++; if (!seen) begin nfail++; $display("FAIL wrap_done_timeout got none want pulse"); end
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); nvec++;
            if (obs_q.size() == 0) begin nfail++; $display("FAIL wrap_write got none want %h/%h", e.addr, e.data); end
            else begin o = obs_q.pop_front();
                if (o !== e) begin nfail++; $display("FAIL wrap_write got %h/%h want %h/%h", o.addr, o.data, e.addr, e.data); end end
        end
    endtask

    task automatic test_async_reset();
        bit seen; logic b; int d0; wr_t e, o;
        gnt_delay = 0; exp_q.delete(); obs_q.delete();
        for (int i = 0; i < 8; i++) push_word(W'(64'hF0 + i));
        start_xfer(32'h3000, 16'd8);
        tick();
        tick();
        // Second request is on the bus with grant high; reset lands before its edge.
        d0 = done_cnt;
        rstn_i = 1'b0;
        #1;
        nvec++; if (mem_req_o !== 1'b0) begin nfail++; $display("FAIL arst_req got %b want 0", mem_req_o); end
        nvec++; if (busy_o !== 1'b0) begin nfail++; $display("FAIL arst_busy got %b want 0", busy_o); end
        nvec++; if (fifo_pop_o !== 1'b0) begin nfail++; $display("FAIL arst_pop got %b want 0", fifo_pop_o); end
        tick(); tick();
        nvec++; if (wr_ptr - rd_ptr != 6) begin nfail++; $display("FAIL arst_fifo_left got %0d want 6", wr_ptr - rd_ptr); end
        rstn_i = 1'b1;
        tick(); tick();
        nvec++; if (done_cnt != d0) begin nfail++; $display("FAIL arst_no_done got %0d pulses want 0", done_cnt - d0); end
        obs_q.delete();
        for (int i = 2; i < 8; i++)
            exp_q.push_back(wr_t'{addr: AW'(32'h4000 + 8 * (i - 2)), data: W'(64'hF0 + i)});
        start_xfer(32'h4000, 16'd6);
        wait_done(30, seen, b);
        nvec++; if (!seen) begin nfail++; $display("FAIL arst_restart_timeout got none want pulse"); end
        tick();
        nvec++; if (!fifo_empty_i) begin nfail++; $display("FAIL arst_fifo_drained got %0d left want 0", wr_ptr - rd_ptr); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); nvec++;
            if (obs_q.size() == 0) begin nfail++; $display("FAIL arst_write got none want %h/%h", e.addr, e.data); end
            else begin o = obs_q.pop_front();
                if (o !== e) begin nfail++; $display("FAIL arst_write got %h/%h want %h/%h", o.addr, o.data, e.addr, e.data); end end
        end
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_backpressure();
        test_starvation();
        test_len_zero();
        test_start_while_busy();
        test_addr_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion want finish within 200000ns");
        $fatal(1, "watchdog expired");
    end

endmodule
